mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage in-order pipeline, between EXE and WB.
- Produces the MEM->WB bus, {pc, final_result, reg_we, reg_waddr}, under the valid/allow_in handshake.
- Issues the data-SRAM request for loads and stores, and waits for the response.
- Extracts and extends load data, and drives a bypass/stall bus back to ID.

Parameters:
EXE_TO_MEM_BUS_WIDTH, 106, {pc[31:0], alu_result[31:0], store_data[31:0], reg_we, reg_waddr[4:0], mem_op[3:0]}
MEM_TO_WB_BUS_WIDTH, 70, {pc[31:0], final_result[31:0], reg_we, reg_waddr[4:0]}
MEM_TO_ID_BUS_WIDTH, 39, {fwd_we, fwd_waddr[4:0], fwd_data[31:0], load_pending}

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
exe_to_mem_valid  in  1  EXE holds a valid instruction
mem_allow_in  out  1  MEM accepts this cycle
exe_to_mem_bus  in  106  instruction payload
wb_allow_in  in  1  WB accepts this cycle
mem_to_wb_valid  out  1  MEM offers a completed instruction
mem_to_wb_bus  out  70  completed payload
mem_to_id_bus  out  39  bypass/stall info
data_sram_req  out  1  request valid
data_sram_wr  out  1  1 = store
data_sram_size  out  2  0 = byte, 1 = half, 2 = word
data_sram_wstrb  out  4  byte write strobes
data_sram_addr  out  32  byte address
data_sram_wdata  out  32  replicated store data
data_sram_addr_ok  in  1  request accepted
data_sram_data_ok  in  1  response valid
data_sram_rdata  in  32  load data

Behaviour:
- Reset (clk rising edge, reset=1) clears the following:
  - mem_valid=0, state=IDLE.
  - data_sram_req=0, mem_to_wb_valid=0.
  - Pipe register and rdata buffer cleared to 0.
- mem_op encoding:
  - 0 = none; 1 = LD.B, 2 = LD.H, 3 = LD.W, 4 = LD.BU, 5 = LD.HU; 6 = ST.B, 7 = ST.H, 8 = ST.W.
  - Codes 9-15 are treated as none.
- Handshake:
  - mem_allow_in = !mem_valid || (mem_ready_go && wb_allow_in).
  - mem_to_wb_valid = mem_valid && mem_ready_go.
  - Payload is captured when mem_allow_in && exe_to_mem_valid.
  - mem_valid <= exe_to_mem_valid whenever mem_allow_in.
- mem_ready_go = (mem_op==none) || state==DONE. Non-memory instructions take 1 cycle in the stage.
- FSM: IDLE, REQ, WAIT, DONE.
  - On capture with a memory op: next state is REQ. On capture without one: IDLE.
  - REQ: data_sram_req=1, with fields held stable until addr_ok; then go to WAIT.
  - WAIT: on data_ok, latch rdata into the buffer, go to DONE.
  - DONE: hold until handoff (mem_to_wb_valid && wb_allow_in).
  - Handoff with simultaneous capture: go to REQ or IDLE according to the new op.
  - Handoff with no capture: go to IDLE.
- data_ok is never asserted before addr_ok has been accepted, nor in the same cycle as that acceptance.
- data_sram_req is combinational from state==REQ && mem_valid. The request is never withdrawn before addr_ok.
- Stores still wait for data_ok (write acknowledge); rdata is ignored for stores.
- Request fields:
  - addr = alu_result.
  - size from op.
  - wr=1 for ST.*.
  - wstrb:
    - ST.B: 4'b0001<<addr[1:0].
    - ST.H: addr[1] ? 4'b1100 : 4'b0011.
    - ST.W: 4'b1111.
    - Loads: 4'b0000.
  - wdata:
    - ST.B: {4{sd[7:0]}}.
    - ST.H: {2{sd[15:0]}}.
    - ST.W: sd.
- Load extract:
  - shifted = buf >> (8*addr[1:0]).
  - LD.B / LD.H: sign-extend bit 7 / bit 15.
  - LD.BU / LD.HU: zero-extend.
  - LD.W: buf unchanged.
- Misaligned addresses are not checked: the lower bits select the lane as above.
- final_result = load ? extracted : alu_result. reg_we and reg_waddr pass through unchanged.
- mem_to_id_bus fields:
  - fwd_we = mem_valid && reg_we.
  - fwd_data = final_result.
  - load_pending = mem_valid && load && state!=DONE. ID stalls on a dependency while this bit is set.
- WB backpressure: in DONE, rdata stays buffered indefinitely, and the SRAM sees no new request.
- Reset mid-transaction: the whole core and the SRAM reset together, so no stale data_ok arrives afterwards.

Decomposition:
- Shared header holds:
  - The three bus-width macros.
  - mem_op codes.
  - State encodings: IDLE=0, REQ=1, WAIT=2, DONE=3.
- One natural sub-module, mem_load_align: takes op, addr[1:0] and rdata, and returns the extended result. It is purely combinational and is reused by a later cache stage.

Test Plan:
- Back-to-back ALU ops, wb_allow_in=1 -> one handoff per cycle; mem_to_wb_bus mirrors pc, alu_result, we, waddr; data_sram_req stays 0.
- LD.B at addr 0x1003, addr_ok after 2 cycles, data_ok 3 cycles later with rdata=0x80AABBCC:
  - result 0xFFFFFF80.
  - load_pending=1 until DONE.
  - mem_allow_in=0 throughout.
- LD.HU at 0x2002 with rdata=0x9234_5678 -> result 0x00009234. LD.H at the same address -> result 0xFFFF9234.
- ST.B at 0x3001 with sd=0x12345678:
  - req with wr=1, size=0, wstrb=4'b0010, wdata=0x78787878.
  - Completes after data_ok.
- LD.W whose data_ok arrives while wb_allow_in=0 for 4 cycles -> state DONE holds the buffered rdata, no second req, and one handoff when wb_allow_in returns.
- Reset asserted in WAIT -> next cycle mem_valid=0, data_sram_req=0, mem_to_wb_valid=0; a fresh LD.W after reset completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: bus widths, memory op codes,
// FSM states and the EXE->MEM payload layout.
package mem_stage_pkg;

  localparam int EXE_TO_MEM_BUS_WIDTH = 106;
  localparam int MEM_TO_WB_BUS_WIDTH  = 70;
  localparam int MEM_TO_ID_BUS_WIDTH  = 39;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LDB  = 4'd1;
  localparam logic [3:0] OP_LDH  = 4'd2;
  localparam logic [3:0] OP_LDW  = 4'd3;
  localparam logic [3:0] OP_LDBU = 4'd4;
  localparam logic [3:0] OP_LDHU = 4'd5;
  localparam logic [3:0] OP_STB  = 4'd6;
  localparam logic [3:0] OP_STH  = 4'd7;
  localparam logic [3:0] OP_STW  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] sd;
    logic        we;
    logic [4:0]  waddr;
    logic [3:0]  op;
  } ex_mem_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LDB) && (op <= OP_LDHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_STB) && (op <= OP_STW);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension; purely combinational
// so a later cache stage can reuse it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  logic [31:0] sh;

  assign sh = rdata_i >> {addr_i, 3'b000};

  always_comb begin
    result_o = rdata_i;
    unique case (1'b1)
      (op_i == OP_LDB):  result_o = {{24{sh[7]}}, sh[7:0]};
      (op_i == OP_LDH):  result_o = {{16{sh[15]}}, sh[15:0]};
      (op_i == OP_LDBU): result_o = {24'd0, sh[7:0]};
      (op_i == OP_LDHU): result_o = {16'd0, sh[15:0]};
      default:           result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-SRAM requests, buffers
// the response and hands completed instructions to WB.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        exe_to_mem_valid,
  output logic        mem_allow_in,
  input  logic [EXE_TO_MEM_BUS_WIDTH-1:0] exe_to_mem_bus,
  input  logic        wb_allow_in,
  output logic        mem_to_wb_valid,
  output logic [MEM_TO_WB_BUS_WIDTH-1:0]  mem_to_wb_bus,
  output logic [MEM_TO_ID_BUS_WIDTH-1:0]  mem_to_id_bus,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata
);

  ex_mem_t     pipe_q;
  ex_mem_t     in_w;
  logic        valid_q;
  mem_state_e  state_q, state_d;
  logic [31:0] rbuf_q;
  logic [31:0] ext;
  logic [31:0] final_res;
  logic        ld, st, ready_go, cap;
  logic        in_mem;

  assign in_w     = ex_mem_t'(exe_to_mem_bus);
  assign ld       = is_load(pipe_q.op);
  assign st       = is_store(pipe_q.op);
  assign in_mem   = is_load(in_w.op) || is_store(in_w.op);
  assign ready_go = !(ld || st) || (state_q == S_DONE);

  assign mem_allow_in    = !valid_q || (ready_go && wb_allow_in);
  assign mem_to_wb_valid = valid_q && ready_go;
  assign cap             = mem_allow_in && exe_to_mem_valid;

  always_comb begin
    state_d = state_q;
    if (mem_allow_in) begin
      state_d = (cap && in_mem) ? S_REQ : S_IDLE;
    end else begin
      unique case (state_q)
        S_REQ:   if (data_sram_addr_ok) state_d = S_WAIT;
        S_WAIT:  if (data_sram_data_ok) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      state_q <= S_IDLE;
      pipe_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      if (mem_allow_in) valid_q <= exe_to_mem_valid;
      if (cap) pipe_q <= in_w;
      if (state_q == S_WAIT && data_sram_data_ok) rbuf_q <= data_sram_rdata;
    end
  end

  assign data_sram_req  = (state_q == S_REQ) && valid_q;
  assign data_sram_wr   = st;
  assign data_sram_addr = pipe_q.alu;

  always_comb begin
    data_sram_size  = 2'd0;
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = pipe_q.sd;
    unique case (1'b1)
      (pipe_q.op == OP_LDH), (pipe_q.op == OP_LDHU):
        data_sram_size = 2'd1;
      (pipe_q.op == OP_LDW):
        data_sram_size = 2'd2;
      (pipe_q.op == OP_STB): begin
        data_sram_wstrb = 4'b0001 << pipe_q.alu[1:0];
        data_sram_wdata = {4{pipe_q.sd[7:0]}};
      end
      (pipe_q.op == OP_STH): begin
        data_sram_size  = 2'd1;
        data_sram_wstrb = pipe_q.alu[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{pipe_q.sd[15:0]}};
      end
      (pipe_q.op == OP_STW): begin
        data_sram_size  = 2'd2;
        data_sram_wstrb = 4'b1111;
      end
      default: data_sram_size = 2'd0;
    endcase
  end

  mem_load_align u_align (
    .op_i    (pipe_q.op),
    .addr_i  (pipe_q.alu[1:0]),
    .rdata_i (rbuf_q),
    .result_o(ext)
  );

  assign final_res = ld ? ext : pipe_q.alu;

  assign mem_to_wb_bus = {pipe_q.pc, final_res,
                          pipe_q.we, pipe_q.waddr};

  assign mem_to_id_bus = {valid_q && pipe_q.we, pipe_q.waddr,
                          final_res,
                          valid_q && ld && (state_q != S_DONE)};

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against an
// arithmetic reference model with a scripted SRAM responder.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk;
  logic         reset;
  logic         exe_valid;
  logic         allow_in;
  logic [105:0] exe_bus;
  logic         wb_allow;
  logic         wb_valid;
  logic [69:0]  wb_bus;
  logic [38:0]  id_bus;
  logic         req, wr;
  logic [1:0]   size;
  logic [3:0]   wstrb;
  logic [31:0]  addr, wdata, rdata;
  logic         addr_ok, data_ok;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .exe_to_mem_valid (exe_valid),
    .mem_allow_in     (allow_in),
    .exe_to_mem_bus   (exe_bus),
    .wb_allow_in      (wb_allow),
    .mem_to_wb_valid  (wb_valid),
    .mem_to_wb_bus    (wb_bus),
    .mem_to_id_bus    (id_bus),
    .data_sram_req    (req),
    .data_sram_wr     (wr),
    .data_sram_size   (size),
    .data_sram_wstrb  (wstrb),
    .data_sram_addr   (addr),
    .data_sram_wdata  (wdata),
    .data_sram_addr_ok(addr_ok),
    .data_sram_data_ok(data_ok),
    .data_sram_rdata  (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [69:0] obs,
                     input logic [69:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_load(input int op);
    return op >= 1 && op <= 5;
  endfunction

  function automatic bit m_store(input int op);
    return op >= 6 && op <= 8;
  endfunction

  function automatic logic [31:0] m_result(input int op,
      input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (8 * (a % 4))) & 32'hFFFF;
    case (op)
      1: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      2: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3: return rd;
      4: return b;
      5: return h;
      default: return a;
    endcase
  endfunction

  function automatic logic [1:0] m_size(input int op);
    if (op == 1 || op == 4 || op == 6) return 2'd0;
    if (op == 2 || op == 5 || op == 7) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [3:0] m_wstrb(input int op,
                                         input logic [31:0] a);
    if (op == 6) return 4'(1 << (a % 4));
    if (op == 7) return (a % 4 >= 2) ? 4'd12 : 4'd3;
    if (op == 8) return 4'd15;
    return 4'd0;
  endfunction

  function automatic logic [31:0] m_wdata(input int op,
                                          input logic [31:0] sd);
    if (op == 6) return (sd & 32'hFF) * 32'h0101_0101;
    if (op == 7) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  task automatic run_instr(input logic [31:0] pc, input logic [31:0] a,
      input logic [31:0] sd, input logic we, input logic [4:0] wa,
      input int op, input logic [31:0] rd, input int ad,
      input int dd, input int stall);
    bit ld, st;
    logic [31:0] res;
    ld  = m_load(op);
    st  = m_store(op);
    res = m_result(op, a, rd);
    @(negedge clk);
    exe_valid = 1'b1;
    exe_bus   = {pc, a, sd, we, wa, 4'(op)};
    wb_allow  = 1'b1;
    #1;
    chk("allow_idle", allow_in, 1'b1);
    chk("wbv_idle", wb_valid, 1'b0);
    @(negedge clk);
    exe_valid = 1'b0;
    exe_bus   = {$urandom, $urandom, $urandom, 10'($urandom)};
    if (ld || st) begin
      for (int i = 0; i <= ad; i++) begin
        addr_ok = (i == ad);
        #1;
        chk("req", req, 1'b1);
        chk("wr", wr, st);
        chk("size", size, m_size(op));
        chk("addr", addr, a);
        chk("wstrb", wstrb, m_wstrb(op, a));
        if (st) chk("wdata", wdata, m_wdata(op, sd));
        chk("allow_req", allow_in, 1'b0);
        chk("lp_req", id_bus[0], ld);
        @(negedge clk);
      end
      addr_ok = 1'b0;
      for (int i = 0; i <= dd; i++) begin
        data_ok = (i == dd);
        rdata   = (i == dd) ? rd : $urandom;
        #1;
        chk("req_wait", req, 1'b0);
        chk("allow_wait", allow_in, 1'b0);
        chk("wbv_wait", wb_valid, 1'b0);
        chk("lp_wait", id_bus[0], ld);
        @(negedge clk);
      end
      data_ok = 1'b0;
      rdata   = $urandom;
    end
    for (int i = 0; i <= stall; i++) begin
      wb_allow = (i == stall);
      #1;
      chk("wbv", wb_valid, 1'b1);
      chk("wb_bus", wb_bus, {pc, res, we, wa});
      chk("id_bus", 70'(id_bus), 70'({we, wa, res, 1'b0}));
      chk("req_done", req, 1'b0);
      chk("allow_done", allow_in, wb_allow);
      if (i < stall) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] pcs [4];
    logic [31:0] alus [4];
    reset     = 1'b1;
    exe_valid = 1'b0;
    exe_bus   = '0;
    wb_allow  = 1'b1;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    rdata     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wbv", wb_valid, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_allow", allow_in, 1'b1);
    chk("rst_wbbus", wb_bus, 70'd0);
    chk("rst_idbus", 70'(id_bus), 70'd0);

    for (int k = 0; k < 4; k++) begin
      pcs[k]  = $urandom;
      alus[k] = $urandom;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exe_valid = 1'b1;
      exe_bus   = {pcs[k], alus[k], 32'hDEAD_BEEF, 1'b1, 5'(k + 1),
                   4'd0};
      #1;
      chk("b2b_allow", allow_in, 1'b1);
      chk("b2b_req", req, 1'b0);
      if (k > 0) begin
        chk("b2b_wbv", wb_valid, 1'b1);
        chk("b2b_bus", wb_bus, {pcs[k-1], alus[k-1], 1'b1, 5'(k)});
      end
    end
    @(negedge clk);
    exe_valid = 1'b0;
    #1;
    chk("b2b_last", wb_bus, {pcs[3], alus[3], 1'b1, 5'd4});
    @(negedge clk);
    #1;
    chk("b2b_drain", wb_valid, 1'b0);

    run_instr(32'h100, 32'h1003, 32'h0, 1'b1, 5'd3, 1,
              32'h80AA_BBCC, 2, 2, 0);
    run_instr(32'h104, 32'h2002, 32'h0, 1'b1, 5'd4, 5,
              32'h9234_5678, 0, 0, 0);
    run_instr(32'h108, 32'h2002, 32'h0, 1'b1, 5'd5, 2,
              32'h9234_5678, 1, 0, 1);
    run_instr(32'h10C, 32'h3001, 32'h1234_5678, 1'b0, 5'd0, 6,
              32'h0, 0, 1, 0);
    run_instr(32'h110, 32'h4000, 32'h0, 1'b1, 5'd6, 3,
              32'hCAFE_F00D, 1, 1, 4);

    @(negedge clk);
    exe_valid = 1'b1;
    exe_bus   = {32'h200, 32'h5000, 32'h0, 1'b1, 5'd7, 4'd3};
    @(negedge clk);
    exe_valid = 1'b0;
    addr_ok   = 1'b1;
    @(negedge clk);
    addr_ok = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst2_req", req, 1'b0);
    chk("rst2_wbv", wb_valid, 1'b0);
    chk("rst2_allow", allow_in, 1'b1);
    chk("rst2_fwdwe", id_bus[38], 1'b0);
    chk("rst2_lp", id_bus[0], 1'b0);
    run_instr(32'h204, 32'h5004, 32'h0, 1'b1, 5'd8, 3,
              32'h1357_9BDF, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      run_instr($urandom, $urandom, $urandom, 1'($urandom),
                5'($urandom), int'($urandom_range(0, 15)), $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
